// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: FSM states, error data
// value and the packed request/response views of the core-facing ports.
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_ctrl_state_e;

  localparam logic [31:0] dmem_err_data_gp = 32'h0;

  typedef struct packed {
    logic        valid;
    logic        wen;
    logic        byte_not_word;
    logic [31:0] addr;
    logic [31:0] write_data;
    logic        yumi;
  } mem_in_s;

  typedef struct packed {
    logic             yumi;
    logic             valid;
    logic [31:0]      read_data;
    logic             err;
    dmem_ctrl_state_e state;
  } mem_out_s;

  // Byte enables for an access: all lanes for a word, one lane for a byte.
  function automatic logic [3:0] lane_be(input logic byte_not_word, input logic [1:0] lane);
    logic [3:0] be;
    be = 4'hF;
    if (byte_not_word) be = 4'b0001 << lane;
    return be;
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Four byte-lane SRAM arrays with per-lane write enable and a registered read.
module dmem_bank #(
  parameter int addr_width_p = 10
) (
  input  logic                    clk,
  input  logic                    we_i,
  input  logic                    re_i,
  input  logic [3:0]              be_i,
  input  logic [addr_width_p-1:0] waddr_i,
  input  logic [addr_width_p-1:0] raddr_i,
  input  logic [31:0]             wdata_i,
  output logic [31:0]             rdata_o
);

  for (genvar l = 0; l < 4; l++) begin : g_lane
    logic [7:0] mem [2**addr_width_p];
    logic [7:0] rd_q;

    always_ff @(posedge clk) begin
      if (we_i && be_i[l]) mem[waddr_i] <= wdata_i[8*l +: 8];
      if (re_i) rd_q <= mem[raddr_i];
    end

    assign rdata_o[8*l +: 8] = rd_q;
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: valid/yumi request accept, fixed-latency access to
// the byte-lane bank, and a response held in RESP until the core yumis it.
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int addr_width_p = 10,
  parameter int latency_p    = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  input  logic        wen_i,
  input  logic        byte_not_word_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  input  logic        yumi_i,
  output logic        yumi_o,
  output logic        valid_o,
  output logic [31:0] read_data_o,
  output logic        err_o,
  output logic        busy_o
);

  localparam logic [3:0] LatM1 = 4'(latency_p - 1);

  // Handshake: a request moves when valid_i and yumi_o are both high in IDLE;
  // a response moves when valid_o and yumi_i are both high in RESP.
  mem_in_s  req_in;
  mem_out_s resp_out;

  dmem_ctrl_state_e state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wen_q, wen_d;
  logic        bnw_q, bnw_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        err_q, err_d;
  logic        zero_q, zero_d;
  logic        yumi;
  logic        bank_we, bank_re;
  logic        req_oor, req_mis;
  logic [31:0] bank_rdata;
  logic [7:0]  lane_byte;
  logic [31:0] load_data;

  assign req_in = '{valid: valid_i, wen: wen_i, byte_not_word: byte_not_word_i,
                    addr: addr_i, write_data: write_data_i, yumi: yumi_i};

  assign req_oor = (addr_q >> (addr_width_p + 2)) != 32'h0;
  assign req_mis = !bnw_q && (addr_q[1:0] != 2'b00);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    wen_d   = wen_q;
    bnw_d   = bnw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    zero_d  = zero_q;
    yumi    = 1'b0;
    bank_we = 1'b0;
    bank_re = 1'b0;
    case (state_q)
      IDLE: begin
        yumi = req_in.valid;
        if (req_in.valid) begin
          wen_d   = req_in.wen;
          bnw_d   = req_in.byte_not_word;
          addr_d  = req_in.addr;
          wdata_d = req_in.write_data;
          cnt_d   = LatM1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          // Access cycle: out-of-range stores never reach the array.
          bank_we = wen_q && !req_oor;
          bank_re = !wen_q && !req_oor;
          zero_d  = wen_q || req_oor;
          err_d   = err_q || req_oor || req_mis;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (req_in.yumi) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      wen_q   <= 1'b0;
      bnw_q   <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      err_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wen_q   <= wen_d;
      bnw_q   <= bnw_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      zero_q  <= zero_d;
    end
  end

  dmem_bank #(.addr_width_p(addr_width_p)) u_bank (
    .clk     (clk),
    .we_i    (bank_we),
    .re_i    (bank_re),
    .be_i    (lane_be(bnw_q, addr_q[1:0])),
    .waddr_i (addr_q[addr_width_p+1:2]),
    .raddr_i (addr_q[addr_width_p+1:2]),
    .wdata_i (bnw_q ? {4{wdata_q[7:0]}} : wdata_q),
    .rdata_o (bank_rdata)
  );

  // Bank read register and request registers are stable through RESP.
  assign lane_byte = bank_rdata[8*addr_q[1:0] +: 8];
  assign load_data = bnw_q ? {24'h0, lane_byte} : bank_rdata;

  assign resp_out = '{yumi: yumi,
                      valid: state_q == RESP,
                      read_data: (state_q == RESP && !zero_q) ? load_data : dmem_err_data_gp,
                      err: err_q,
                      state: state_q};

  assign yumi_o      = resp_out.yumi;
  assign valid_o     = resp_out.valid;
  assign read_data_o = resp_out.read_data;
  assign err_o       = resp_out.err;
  assign busy_o      = resp_out.state != IDLE;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: two instances (latency 2 and 4) behind one selectable
// driver, a word-array memory model, and a per-cycle response compare.
module tb_dmem_ctrl;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic valid, wen, bnw, yumi_in;
  logic [31:0] addr, wdata;
  bit   sel;

  logic [1:0]  yumi_v, valid_v, err_v, busy_v;
  logic [31:0] rd_v [2];

  logic        yumi_m, valid_m, err_m_dut, busy_m, rst_m;
  logic [31:0] rd_m;

  logic [31:0] mem_m [2][2**AW];
  bit          err_m [2];
  logic [31:0] exp_q [$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int last_yumi_cyc = -10;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dmem_ctrl #(.addr_width_p(AW), .latency_p(2)) u_dut_l2 (
    .clk(clk), .reset(rst_a), .valid_i(valid && !sel), .wen_i(wen),
    .byte_not_word_i(bnw), .addr_i(addr), .write_data_i(wdata),
    .yumi_i(yumi_in && !sel), .yumi_o(yumi_v[0]), .valid_o(valid_v[0]),
    .read_data_o(rd_v[0]), .err_o(err_v[0]), .busy_o(busy_v[0]));

  dmem_ctrl #(.addr_width_p(AW), .latency_p(4)) u_dut_l4 (
    .clk(clk), .reset(rst_b), .valid_i(valid && sel), .wen_i(wen),
    .byte_not_word_i(bnw), .addr_i(addr), .write_data_i(wdata),
    .yumi_i(yumi_in && sel), .yumi_o(yumi_v[1]), .valid_o(valid_v[1]),
    .read_data_o(rd_v[1]), .err_o(err_v[1]), .busy_o(busy_v[1]));

  assign yumi_m    = yumi_v[sel];
  assign valid_m   = valid_v[sel];
  assign rd_m      = rd_v[sel];
  assign err_m_dut = err_v[sel];
  assign busy_m    = busy_v[sel];
  assign rst_m     = sel ? rst_b : rst_a;

  task automatic check(input bit ok, input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response compare: every cycle the selected DUT shows a response.
  always @(negedge clk) begin
    if (!rst_m) begin
      if (yumi_m && busy_m) check(1'b0, "yumi_outside_idle", 32'(yumi_m), 32'h0);
      if (valid_m) begin
        check(busy_m == 1'b1, "busy_in_resp", 32'(busy_m), 32'h1);
        check(err_m_dut == err_m[sel], "err_in_resp", 32'(err_m_dut), 32'(err_m[sel]));
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_valid", 32'(valid_m), 32'h0);
        end else begin
          check(rd_m === exp_q[0], "read_data", rd_m, exp_q[0]);
          if (yumi_in) void'(exp_q.pop_front());
        end
      end
    end
  end

  // Model: the memory as a plain word array; expected response per request.
  function automatic logic [31:0] model_access(input bit w, input bit b, input logic [31:0] a, input logic [31:0] d);
    int          idx, lane;
    bit          oor;
    logic [31:0] word;
    oor  = (a >= 32'(4 * (2**AW)));
    idx  = int'((a / 4) % (2**AW));
    lane = int'(a % 4);
    if (oor || (!b && lane != 0)) err_m[sel] = 1'b1;
    if (oor) return 32'h0;
    word = mem_m[sel][idx];
    if (w) begin
      if (b) word[8*lane +: 8] = d[7:0];
      else   word = d;
      mem_m[sel][idx] = word;
      return 32'h0;
    end
    if (b) return {24'h0, word[8*lane +: 8]};
    return word;
  endfunction

  task automatic issue(input bit w, input bit b, input logic [31:0] a, input logic [31:0] d,
                       input int hold, input bit keep, input bit b2b, output logic [31:0] got);
    int n, acc, lat;
    lat = sel ? 4 : 2;
    exp_q.push_back(model_access(w, b, a, d));
    valid = 1'b1; wen = w; bnw = b; addr = a; wdata = d;
    #1;
    n = 0;
    while (!yumi_m && n < 20) begin @(negedge clk); n++; end
    check(yumi_m == 1'b1, "accept_yumi", 32'(yumi_m), 32'h1);
    acc = cyc;
    if (b2b) check(acc == last_yumi_cyc + 1, "b2b_accept_cycle", 32'(acc), 32'(last_yumi_cyc + 1));
    @(posedge clk); #1;
    if (!keep) valid = 1'b0;
    n = 0;
    while (!valid_m && n < 40) begin @(negedge clk); n++; end
    check(valid_m == 1'b1 && cyc == acc + lat + 1, "resp_latency", 32'(cyc - acc), 32'(lat + 1));
    got = rd_m;
    for (int i = 0; i < hold; i++) @(negedge clk);
    @(posedge clk); #1;
    yumi_in = 1'b1;
    @(negedge clk);
    last_yumi_cyc = cyc;
    @(posedge clk); #1;
    yumi_in = 1'b0;
    @(negedge clk);
    check(valid_m == 1'b0 && busy_m == 1'b0, "back_to_idle", {busy_m, valid_m}, 32'h0);
  endtask

  logic [31:0] got, hold_val;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; rst_b = 1'b1; sel = 1'b0;
    valid = 1'b0; wen = 1'b0; bnw = 1'b0; addr = '0; wdata = '0; yumi_in = 1'b1;
    repeat (3) @(negedge clk);
    check(valid_m == 1'b0 && yumi_m == 1'b0, "reset_valid_yumi", {yumi_m, valid_m}, 32'h0);
    check(err_m_dut == 1'b0 && busy_m == 1'b0, "reset_err_busy", {err_m_dut, busy_m}, 32'h0);
    check(rd_m == 32'h0, "reset_read_data", rd_m, 32'h0);
    rst_a = 1'b0; rst_b = 1'b0; yumi_in = 1'b0;
    @(negedge clk);
    check(valid_m == 1'b0 && busy_m == 1'b0, "yumi_i_in_idle_ignored", {busy_m, valid_m}, 32'h0);

    // Word store then load.
    issue(1, 0, 32'h40, 32'hCAFEF00D, 0, 0, 0, got);
    check(got == 32'h0, "store_resp_zero", got, 32'h0);
    issue(0, 0, 32'h40, 32'h0, 0, 0, 0, got);
    check(got == 32'hCAFEF00D, "word_load", got, 32'hCAFEF00D);
    check(err_m_dut == 1'b0, "no_err", 32'(err_m_dut), 32'h0);

    // Byte lanes.
    issue(1, 0, 32'h80, 32'h11223344, 0, 0, 0, got);
    issue(1, 1, 32'h82, 32'h555555AA, 0, 0, 0, got);
    issue(0, 0, 32'h80, 32'h0, 0, 0, 0, got);
    check(got == 32'h11AA3344, "byte_merge", got, 32'h11AA3344);
    issue(0, 1, 32'h83, 32'h0, 0, 0, 0, got);
    check(got == 32'h00000011, "byte_load_lane3", got, 32'h00000011);
    issue(0, 1, 32'h80, 32'h0, 0, 0, 0, got);
    check(got == 32'h00000044, "byte_load_lane0", got, 32'h00000044);

    // Back-pressure with valid_i held high, then an immediate follow-on accept.
    issue(0, 0, 32'h80, 32'h0, 5, 1, 0, hold_val);
    issue(0, 0, 32'h40, 32'h0, 0, 0, 1, got);
    check(hold_val == 32'h11AA3344 && got == 32'hCAFEF00D, "backpressure_pair", got, 32'hCAFEF00D);

    // Out-of-range store must not alias onto word 0.
    issue(1, 0, 32'h0, 32'h01020304, 0, 0, 0, got);
    issue(1, 0, 32'h0010_0000, 32'hDEADBEEF, 0, 0, 0, got);
    check(err_m_dut == 1'b1, "oor_err", 32'(err_m_dut), 32'h1);
    issue(0, 0, 32'h0, 32'h0, 0, 0, 0, got);
    check(got == 32'h01020304, "oor_store_suppressed", got, 32'h01020304);
    issue(0, 0, 32'h0010_0000, 32'h0, 0, 0, 0, got);
    check(got == 32'h0, "oor_load_zero", got, 32'h0);

    // Misaligned word load after clearing the sticky error.
    rst_a = 1'b1; err_m[0] = 1'b0;
    #1;
    check(err_m_dut == 1'b0, "err_cleared_by_reset", 32'(err_m_dut), 32'h0);
    @(negedge clk); rst_a = 1'b0; @(negedge clk);
    issue(0, 0, 32'h41, 32'h0, 0, 0, 0, got);
    check(got == 32'hCAFEF00D && err_m_dut == 1'b1, "misaligned_aligned_down", got, 32'hCAFEF00D);

    // Latency-4 instance: reset in the second WAIT cycle drops the store.
    sel = 1'b1;
    @(negedge clk);
    issue(1, 0, 32'h10, 32'hA5A50001, 0, 0, 0, got);
    valid = 1'b1; wen = 1'b1; bnw = 1'b0; addr = 32'h10; wdata = 32'h12345678;
    #1;
    check(yumi_m == 1'b1, "l4_accept", 32'(yumi_m), 32'h1);
    @(posedge clk); #1; valid = 1'b0;
    @(posedge clk); #1;
    check(busy_m == 1'b1, "l4_in_wait", 32'(busy_m), 32'h1);
    rst_b = 1'b1;
    #1;
    check(valid_m == 1'b0 && busy_m == 1'b0, "reset_mid_wait", {busy_m, valid_m}, 32'h0);
    @(negedge clk); rst_b = 1'b0; @(negedge clk);
    issue(0, 0, 32'h10, 32'h0, 2, 0, 0, got);
    check(got == 32'hA5A50001, "store_discarded", got, 32'hA5A50001);
    issue(1, 1, 32'h11, 32'h000000EE, 0, 0, 0, got);
    issue(0, 0, 32'h10, 32'h0, 0, 0, 0, got);
    check(got == 32'hA5A5EE01, "l4_byte_merge", got, 32'hA5A5EE01);

    check(exp_q.size() == 0, "queue_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Data-memory controller directly downstream of the core's LD/ST stage.
- Consumes the core's memory request (valid, wen, byte_not_word, yumi, write_data, data_mem_addr) and returns the yumi/valid/read_data response.
- Implements the two-phase valid/yumi handshake the core's DMEM_IDLE → REQ_SENT → REQ_ACKED → IDLE sequence expects, over an internal byte-lane SRAM with configurable access latency.

Parameters:
- addr_width_p, 10: word-address width; memory depth is 2**addr_width_p 32-bit words.
- latency_p, 2: cycles between request acceptance and response valid; legal range 1..15.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- valid_i  in  1  request valid (core to_mem_o.valid)
- wen_i  in  1  1 = store, 0 = load
- byte_not_word_i  in  1  1 = byte access, 0 = 32-bit word access
- addr_i  in  32  byte address (core data_mem_addr)
- write_data_i  in  32  store data; byte stores use bits [7:0]
- yumi_i  in  1  core accepts response (core to_mem_o.yumi)
- yumi_o  out  1  request accepted (core from_mem_i.yumi)
- valid_o  out  1  response valid (core from_mem_i.valid)
- read_data_o  out  32  load result (core from_mem_i.read_data)
- err_o  out  1  sticky access error
- busy_o  out  1  state != IDLE

Behaviour:
Reset values:
- State IDLE; yumi_o, valid_o, err_o and busy_o are 0; read_data_o is 0; latency counter is 0.
- Memory contents are not cleared by reset.

State machine (IDLE, WAIT, RESP):
- IDLE:
  - yumi_o = valid_i (combinational, this cycle only).
  - When valid_i is high, capture wen, byte_not_word, addr and write_data into request registers, load the counter with latency_p-1, and go to WAIT.
- WAIT:
  - Decrement the counter each cycle.
  - When the counter is 0: perform the array access (store write or load read into the read_data register), then go to RESP.
  - Total latency from the accept cycle to the first valid_o cycle is latency_p+1 cycles.
  - valid_i is ignored and yumi_o is 0.
- RESP:
  - valid_o = 1; read_data_o is held stable.
  - When yumi_i is high, go to IDLE. A new request can be accepted no earlier than the next cycle, so there are no same-cycle back-to-back requests.
  - valid_i high while in RESP is not acknowledged.

Store response:
- Stores also complete through RESP with valid_o = 1, because the core waits for valid before committing.
- read_data_o is 0 for a store response.

Addressing:
- Word index = addr[addr_width_p+1:2]; byte lane = addr[1:0].
- Word load returns the full word. Word store writes all 4 lanes.
- Byte load returns the selected lane zero-extended to 32 bits. Byte store writes write_data[7:0] to the selected lane only; the other lanes are unchanged.

Errors:
- Out of range: any addr bit at or above addr_width_p+2 is set. The store is suppressed, a load returns 0, and err_o is set.
- Misaligned word access: addr[1:0] != 0 with byte_not_word = 0. The access is aligned down and err_o is set.
- err_o stays set until reset. The handshake always completes normally on an error.

Boundary conditions:
- Reset asserted mid-operation: the state returns to IDLE asynchronously, the pending access is discarded, and a store that has not yet reached its access cycle is not written.
- yumi_i high outside RESP: ignored.
- latency_p = 1: WAIT lasts 1 cycle.
- Address wrap-around is never performed; out-of-range addresses are errors.

Decomposition:
- Shared package (definitions):
  - dmem_ctrl_state_e {IDLE, WAIT, RESP}.
  - Constant dmem_err_data_gp = 32'h0, the load-on-error value.
  - Existing mem_in_s / mem_out_s: the top level packs and unpacks the flat ports into these structs.
- Sub-module dmem_bank:
  - 4 byte-lane arrays.
  - Synchronous write with a 4-bit byte enable.
  - Read registered on the access cycle.
  - Ports: clk, we_i, be_i[3:0], waddr/raddr, wdata_i, rdata_o.

Test Plan:
- Word store then load, latency_p = 2: store 0xCAFEF00D to addr 0x40 → yumi_o high in the accept cycle; valid_o 3 cycles later with read_data_o = 0. Load from 0x40 → read_data_o = 0xCAFEF00D; err_o stays 0.
- Byte lanes: word store 0x11223344 to 0x80, then byte store 0xAA to 0x82, then word load 0x80 → 0x11AA3344. Byte load 0x83 → 0x00000011.
- Response back-pressure: hold yumi_i low for 5 cycles in RESP → valid_o stays high and read_data_o stays stable. Raise yumi_i → IDLE the next cycle. Keep valid_i high throughout → the next accept occurs one cycle after the yumi_i cycle.
- Errors: word load at 0x41 → returns the word at 0x40, err_o = 1. Store to 0x0010_0000 (addr_width_p = 10) → the array is unchanged and a subsequent load of the aliased index returns the old value.
- Reset mid-WAIT: store 0x12345678 to 0x10 with latency_p = 4; assert reset on the 2nd WAIT cycle → valid_o = 0 and busy_o = 0 immediately. A later load of 0x10 returns the prior contents.
- Core integration: a core program of SW / LW / LB with latency_p ∈ {1, 3} → register results match golden values and the core's mem_stage returns to DMEM_IDLE after each access.
